// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage pipeline.
// Owns the PC and fetches one word per request from a variable-latency
// instruction memory using a req/ack handshake. It presents
// {inst, pc, pc+4, valid} to the IF/ID register and inserts NOP bubbles
// while the memory is slow or after a redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall_if,
  input  logic        flush_if,
  input  logic [1:0]  pc_sel_ex,
  input  logic [31:0] br_target_ex,
  input  logic [31:0] jalr_target_ex,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_if,
  output logic [31:0] pc_if,
  output logic [31:0] pc_add4_if,
  output logic        valid_if,
  output logic        fetch_busy
);

  // S_IDLE : single settle cycle after reset release
  // S_REQ  : request at pc_q outstanding (or being acked this cycle)
  // S_HOLD : word arrived during a stall and waits in the holding buffer
  // S_DROP : request at a stale address must finish; its data is thrown away
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;

  // Fetch PC and the address of an abandoned request still owed an ack
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;

  // Holding buffer for a word that arrived while IF was stalled
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;

  // Registered outputs towards IF/ID
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_if_q, pc_if_d;
  logic [31:0] pc_add4_q, pc_add4_d;
  logic        valid_q, valid_d;

  // Redirect decode: only 01 (jalr) and 10 (branch/jal) carry a target
  logic        sel_jalr;
  logic        sel_br;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic [31:0] buf_pc_plus4;

  // Decode the redirect request and its target address
  always_comb begin
    sel_jalr        = (pc_sel_ex == 2'b01);
    sel_br          = (pc_sel_ex == 2'b10);
    redirect        = flush_if & (sel_jalr | sel_br);
    redirect_target = br_target_ex;
    if (sel_jalr) begin
      // jalr targets are forced to even addresses
      redirect_target = jalr_target_ex & ~32'h0000_0001;
    end
    pc_plus4        = pc_q + 32'd4;
    buf_pc_plus4    = buf_pc_q + 32'd4;
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush_if outranks stall_if, which outranks normal flow
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect) begin
          // An unacked request cannot be withdrawn; wait it out in S_DROP
          state_d = imem_ack ? S_REQ : S_DROP;
        end else if (flush_if) begin
          state_d = S_REQ;
        end else if (stall_if && imem_ack) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (flush_if || !stall_if) begin
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory-side outputs decoded from the current state
  always_comb begin
    imem_req   = (state_q == S_REQ) || (state_q == S_DROP);
    imem_addr  = (state_q == S_DROP) ? drop_addr_q : pc_q;
    fetch_busy = ((state_q == S_REQ) && !imem_ack) || (state_q == S_DROP);
  end

  // Datapath next values: PC, holding buffer and IF/ID outputs
  always_comb begin
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    buf_inst_d  = buf_inst_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;
    inst_d      = inst_q;
    pc_if_d     = pc_if_q;
    valid_d     = valid_q;
    case (state_q)
      S_IDLE: begin
        if (flush_if) begin
          inst_d  = NOP_INST;
          valid_d = 1'b0;
          if (redirect) begin
            pc_d = redirect_target;
          end
        end
      end
      S_REQ: begin
        if (redirect) begin
          // Any same-cycle response belongs to the wrong path and is ignored
          pc_d    = redirect_target;
          inst_d  = NOP_INST;
          valid_d = 1'b0;
          if (!imem_ack) begin
            drop_addr_d = pc_q;
          end
        end else if (flush_if) begin
          // Squash without redirect: the word is discarded and refetched
          inst_d  = NOP_INST;
          valid_d = 1'b0;
        end else if (stall_if) begin
          if (imem_ack) begin
            buf_inst_d  = imem_rdata;
            buf_pc_d    = pc_q;
            buf_valid_d = 1'b1;
          end
        end else if (imem_ack) begin
          inst_d  = imem_rdata;
          pc_if_d = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end else begin
          inst_d  = NOP_INST;
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (flush_if) begin
          buf_valid_d = 1'b0;
          inst_d      = NOP_INST;
          valid_d     = 1'b0;
          if (redirect) begin
            pc_d = redirect_target;
          end
        end else if (!stall_if) begin
          inst_d      = buf_inst_q;
          pc_if_d     = buf_pc_q;
          valid_d     = buf_valid_q;
          pc_d        = buf_pc_plus4;
          buf_valid_d = 1'b0;
        end
      end
      S_DROP: begin
        // A further redirect only retargets the PC; output stays a bubble
        if (redirect) begin
          pc_d = redirect_target;
        end
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
    pc_add4_d = pc_if_d + 32'd4;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      buf_inst_q  <= NOP_INST;
      buf_pc_q    <= RESET_PC;
      buf_valid_q <= 1'b0;
      inst_q      <= NOP_INST;
      pc_if_q     <= RESET_PC;
      pc_add4_q   <= RESET_PC + 32'd4;
      valid_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      buf_inst_q  <= buf_inst_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
      inst_q      <= inst_d;
      pc_if_q     <= pc_if_d;
      pc_add4_q   <= pc_add4_d;
      valid_q     <= valid_d;
    end
  end

  // Drive the IF/ID outputs straight from their registers
  always_comb begin
    inst_if    = inst_q;
    pc_if      = pc_if_q;
    pc_add4_if = pc_add4_q;
    valid_if   = valid_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a behavioural model
// and a small memory that can stretch one chosen request by N wait cycles.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rstn;
  logic        stall_if;
  logic        flush_if;
  logic [1:0]  pc_sel_ex;
  logic [31:0] br_target_ex;
  logic [31:0] jalr_target_ex;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst_if;
  logic [31:0] pc_if;
  logic [31:0] pc_add4_if;
  logic        valid_if;
  logic        fetch_busy;

  int checks   = 0;
  int failures = 0;

  // Slow-request control: the next request at slow_addr after slow_gen
  // changes waits slow_n cycles before its ack.
  logic [31:0] slow_addr = 32'hFFFF_FFF0;
  int          slow_n    = 0;
  int          slow_gen  = 0;

  fetch_stage dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall_if      (stall_if),
    .flush_if      (flush_if),
    .pc_sel_ex     (pc_sel_ex),
    .br_target_ex  (br_target_ex),
    .jalr_target_ex(jalr_target_ex),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_if       (inst_if),
    .pc_if         (pc_if),
    .pc_add4_if    (pc_add4_if),
    .valid_if      (valid_if),
    .fetch_busy    (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: answers on negedge+1 while imem_req is high
  initial begin
    int wait_left;
    int used_gen;
    wait_left  = -1;
    used_gen   = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (imem_req === 1'b1) begin
        if (wait_left < 0) begin
          wait_left = 0;
          if (slow_gen != used_gen && imem_addr == slow_addr) begin
            wait_left = slow_n;
            used_gen  = slow_gen;
          end
        end
        if (wait_left == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wait_left  = -1;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'h0;
          wait_left--;
        end
      end else begin
        imem_ack   = 1'b0;
        wait_left  = -1;
      end
    end
  end

  // Behavioural model of what IF must show
  logic        m_idle, m_held, m_stale;
  logic [31:0] m_pc, m_stale_addr, m_hw, m_hpc;
  logic [31:0] m_inst, m_pc_if;
  logic        m_valid;

  task model_reset();
    m_idle = 1'b1; m_held = 1'b0; m_stale = 1'b0;
    m_pc = 32'h0; m_stale_addr = 32'h0; m_hw = 32'h0; m_hpc = 32'h0;
    m_inst = NOP; m_pc_if = 32'h0; m_valid = 1'b0;
  endtask

  task model_bubble();
    m_inst  = NOP;
    m_valid = 1'b0;
  endtask

  task model_deliver(input logic [31:0] w, input logic [31:0] p);
    m_inst  = w;
    m_pc_if = p;
    m_valid = 1'b1;
    $display("fetch pc=%08h inst=%08h t=%0t", p, w, $time);
  endtask

  // Advance the model by one clock using the inputs applied this cycle
  task model_step();
    logic        redir;
    logic [31:0] tgt;
    redir = flush_if && (pc_sel_ex == 2'b01 || pc_sel_ex == 2'b10);
    tgt   = (pc_sel_ex == 2'b01) ? {jalr_target_ex[31:1], 1'b0} : br_target_ex;
    if (m_idle) begin
      m_idle = 1'b0;
      if (flush_if) model_bubble();
      if (redir) m_pc = tgt;
    end else if (m_held) begin
      if (flush_if) begin
        m_held = 1'b0;
        model_bubble();
        if (redir) m_pc = tgt;
      end else if (!stall_if) begin
        m_held = 1'b0;
        model_deliver(m_hw, m_hpc);
        m_pc = m_hpc + 32'd4;
      end
    end else if (m_stale) begin
      if (redir) m_pc = tgt;
      if (imem_ack) m_stale = 1'b0;
      model_bubble();
    end else begin
      if (redir) begin
        model_bubble();
        if (!imem_ack) begin
          m_stale      = 1'b1;
          m_stale_addr = m_pc;
        end
        m_pc = tgt;
      end else if (flush_if) begin
        model_bubble();
      end else if (stall_if) begin
        if (imem_ack) begin
          m_held = 1'b1;
          m_hw   = imem_rdata;
          m_hpc  = m_pc;
        end
      end else if (imem_ack) begin
        model_deliver(imem_rdata, m_pc);
        m_pc = m_pc + 32'd4;
      end else begin
        model_bubble();
      end
    end
  endtask

  // Compare process: every cycle at negedge+4, DUT against the model
  initial begin
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_busy;
    model_reset();
    forever begin
      @(negedge clk);
      #4;
      if (!rstn) model_reset();
      exp_req  = !m_idle && !m_held && rstn;
      exp_addr = m_stale ? m_stale_addr : m_pc;
      exp_busy = exp_req && (m_stale || !imem_ack);
      chk("m_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) chk("m_addr", imem_addr, exp_addr);
      chk("m_busy", {31'b0, fetch_busy}, {31'b0, exp_busy});
      chk("m_inst", inst_if, m_inst);
      chk("m_pc", pc_if, m_pc_if);
      chk("m_pc4", pc_add4_if, m_pc_if + 32'd4);
      chk("m_valid", {31'b0, valid_if}, {31'b0, m_valid});
      if (rstn) model_step();
    end
  end

  // Directed stimulus with hand-computed literal expectations
  initial begin
    rstn = 1'b0; stall_if = 1'b0; flush_if = 1'b0; pc_sel_ex = 2'b00;
    br_target_ex = 32'h0; jalr_target_ex = 32'h0;
    slow_addr = 32'h8; slow_n = 2; slow_gen = 1;
    repeat (2) begin
      @(negedge clk); #4;
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_inst", inst_if, 32'h13);
      chk("rst_pc4", pc_add4_if, 32'h4);
      chk("rst_valid", {31'b0, valid_if}, 32'd0);
    end
    // c0: release reset, settle cycle
    @(negedge clk); rstn = 1'b1; #4;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    // c1..c6: zero-wait fetch then 2-cycle wait at 0x8
    @(negedge clk); #4; chk("c1_addr", imem_addr, 32'h0);
    @(negedge clk); #4; chk("c2_addr", imem_addr, 32'h4);
    chk("c2_pc", pc_if, 32'h0); chk("c2_inst", inst_if, 32'hC0DE_0000);
    @(negedge clk); #4; chk("c3_addr", imem_addr, 32'h8);
    chk("c3_busy", {31'b0, fetch_busy}, 32'd1);
    @(negedge clk); #4; chk("c4_addr", imem_addr, 32'h8);
    chk("c4_inst", inst_if, 32'h13); chk("c4_valid", {31'b0, valid_if}, 32'd0);
    @(negedge clk); #4;
    chk("c5_busy", {31'b0, fetch_busy}, 32'd0);
    // c6..c8: stall coinciding with ack of 0xC
    @(negedge clk); stall_if = 1'b1; #4; chk("c6_addr", imem_addr, 32'hC);
    @(negedge clk); #4;
    chk("c7_req", {31'b0, imem_req}, 32'd0); chk("c7_pc", pc_if, 32'h8);
    @(negedge clk); #4;
    // c9: release stall, held word presented
    @(negedge clk); stall_if = 1'b0; slow_addr = 32'h14; slow_n = 3; slow_gen = 2; #4;
    @(negedge clk); #4;
    chk("c10_addr", imem_addr, 32'h10); chk("c10_pc", pc_if, 32'hC);
    // c11: branch redirect while 0x14 is unacked
    @(negedge clk); flush_if = 1'b1; pc_sel_ex = 2'b10; br_target_ex = 32'h40; #4;
    @(negedge clk); flush_if = 1'b0; pc_sel_ex = 2'b00; #4;
    chk("c12_addr", imem_addr, 32'h14); chk("c12_valid", {31'b0, valid_if}, 32'd0);
    @(negedge clk); #4; chk("c13_addr", imem_addr, 32'h14);
    @(negedge clk); #4;
    @(negedge clk); #4; chk("c15_addr", imem_addr, 32'h40);
    @(negedge clk); #4;
    chk("c16_pc", pc_if, 32'h40); chk("c16_valid", {31'b0, valid_if}, 32'd1);
    // c17: jalr redirect with stall and same-cycle ack; flush wins
    @(negedge clk); flush_if = 1'b1; stall_if = 1'b1; pc_sel_ex = 2'b01;
    jalr_target_ex = 32'h81; #4;
    @(negedge clk); flush_if = 1'b0; stall_if = 1'b0; pc_sel_ex = 2'b00;
    slow_addr = 32'h84; slow_n = 4; slow_gen = 3; #4;
    chk("c18_addr", imem_addr, 32'h80); chk("c18_valid", {31'b0, valid_if}, 32'd0);
    // c19: redirect while 0x84 is slow -> drop state
    @(negedge clk); flush_if = 1'b1; pc_sel_ex = 2'b10; br_target_ex = 32'h200; #4;
    chk("c19_pc", pc_if, 32'h80);
    @(negedge clk); flush_if = 1'b0; pc_sel_ex = 2'b00; #4;
    chk("c20_addr", imem_addr, 32'h84); chk("c20_busy", {31'b0, fetch_busy}, 32'd1);
    // c21: reset pulse during drop
    @(negedge clk); rstn = 1'b0; #4;
    chk("c21_req", {31'b0, imem_req}, 32'd0); chk("c21_pc", pc_if, 32'h0);
    @(negedge clk); rstn = 1'b1; #4;
    @(negedge clk); #4; chk("c23_addr", imem_addr, 32'h0);
    // c24: redirect to the top of the address space, then wrap
    @(negedge clk); flush_if = 1'b1; pc_sel_ex = 2'b10; br_target_ex = 32'hFFFF_FFFC; #4;
    @(negedge clk); flush_if = 1'b0; pc_sel_ex = 2'b00; #4;
    chk("c25_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #4;
    chk("c26_addr", imem_addr, 32'h0); chk("c26_pc", pc_if, 32'hFFFF_FFFC);
    chk("c26_pc4", pc_add4_if, 32'h0);
    // c27: flush without redirect squashes and refetches
    @(negedge clk); flush_if = 1'b1; #4;
    chk("c27_pc4", pc_add4_if, 32'h4);
    @(negedge clk); flush_if = 1'b0; slow_addr = 32'h8; slow_n = 2; slow_gen = 4; #4;
    chk("c28_addr", imem_addr, 32'h4); chk("c28_valid", {31'b0, valid_if}, 32'd0);
    // c29..c30: stall while memory is slow; outputs frozen
    @(negedge clk); stall_if = 1'b1; #4;
    @(negedge clk); #4;
    @(negedge clk); stall_if = 1'b0; #4;
    chk("c31_pc", pc_if, 32'h4); chk("c31_valid", {31'b0, valid_if}, 32'd1);
    repeat (4) begin
      @(negedge clk); #4;
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute guard so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
